// File: rtl/idx_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : idx_buf_pkg
//  Description : Shared constants and width helpers for the ping-pong index
//                buffer (block size default, derived widths, bank count).
//  Revision    : 1.0 - initial release
// ============================================================================
package idx_buf_pkg;

    localparam int unsigned K_DEFAULT = 1024;
    localparam int unsigned NUM_BANKS = 2;

    // Index entries address a block of k nodes.
    function automatic int unsigned data_w_of(input int unsigned k);
        return $clog2(k);
    endfunction

    // A bank holds one adjacency block of k*k/32 entries.
    function automatic int unsigned depth_of(input int unsigned k);
        return (k * k) / 32;
    endfunction

    function automatic int unsigned addr_w_of(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/indice_pingpong_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : indice_pingpong_buffer_if
//  Description : Producer write stream plus consumer read/release bus of the
//                ping-pong index buffer. master = loader/engine side,
//                slave = the buffer itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface indice_pingpong_buffer_if #(
    parameter int unsigned DATA_W = idx_buf_pkg::data_w_of(idx_buf_pkg::K_DEFAULT),
    parameter int unsigned ADDR_W = idx_buf_pkg::addr_w_of(
                                        idx_buf_pkg::depth_of(idx_buf_pkg::K_DEFAULT)),
    parameter int unsigned NUM_RD = 2
) ();

    logic                       wr_valid;
    logic                       wr_ready;
    logic [DATA_W-1:0]          wr_data;
    logic                       wr_last;
    logic                       wr_abort;
    logic                       rd_bank_valid;
    logic [ADDR_W:0]            rd_count;
    logic [NUM_RD-1:0]          rd_en;
    logic [NUM_RD*ADDR_W-1:0]   rd_addr;
    logic [NUM_RD*DATA_W-1:0]   rd_data;
    logic [NUM_RD-1:0]          rd_data_valid;
    logic                       rd_release;
    logic [1:0]                 occupancy;

    modport master (
        output wr_valid, wr_data, wr_last, wr_abort, rd_en, rd_addr, rd_release,
        input  wr_ready, rd_bank_valid, rd_count, rd_data, rd_data_valid, occupancy
    );

    modport slave (
        input  wr_valid, wr_data, wr_last, wr_abort, rd_en, rd_addr, rd_release,
        output wr_ready, rd_bank_valid, rd_count, rd_data, rd_data_valid, occupancy
    );

endinterface
`default_nettype wire

// File: rtl/idx_tdp_ram.sv
`default_nettype none
// ============================================================================
//  Module      : idx_tdp_ram
//  Description : True dual-port RAM with registered read. Port A reads or
//                writes, port B reads only. No reset on the array or the
//                read registers; callers mask stale read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module idx_tdp_ram
    import idx_buf_pkg::*;
#(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned DEPTH  = 32768,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              i_a_en,
    input  wire logic              i_a_we,
    input  wire logic [ADDR_W-1:0] i_a_addr,
    input  wire logic [DATA_W-1:0] i_a_wdata,
    output logic      [DATA_W-1:0] o_a_rdata,
    input  wire logic              i_b_en,
    input  wire logic [ADDR_W-1:0] i_b_addr,
    output logic      [DATA_W-1:0] o_b_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Port A: write, or registered read when not writing.
    always_ff @(posedge clk) begin
        if (i_a_en) begin
            if (i_a_we) begin
                r_mem[i_a_addr] <= i_a_wdata;
            end else begin
                o_a_rdata <= r_mem[i_a_addr];
            end
        end
    end

    // Port B: registered read only.
    always_ff @(posedge clk) begin
        if (i_b_en) begin
            o_b_rdata <= r_mem[i_b_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/indice_pingpong_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : indice_pingpong_buffer
//  Description : Two-bank ping-pong index buffer. The producer streams blocks
//                into the fill bank while the consumer random-reads the drain
//                bank on NUM_RD (1 or 2) ports; banks swap automatically on
//                block close and consumer release.
//  Revision    : 1.0 - initial release
// ============================================================================
module indice_pingpong_buffer
    import idx_buf_pkg::*;
#(
    parameter int unsigned K      = K_DEFAULT,
    parameter int unsigned DATA_W = data_w_of(K),
    parameter int unsigned DEPTH  = depth_of(K),
    parameter int unsigned ADDR_W = addr_w_of(DEPTH),
    parameter int unsigned NUM_RD = 2
) (
    input  wire logic               clk,
    input  wire logic               rst,
    indice_pingpong_buffer_if.slave bus
);

    localparam int unsigned        c_CNT_W    = ADDR_W + 1;
    localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);

    logic                 r_fill_sel;
    logic                 r_drain_sel;
    logic [NUM_BANKS-1:0] r_full;
    logic [NUM_BANKS-1:0] w_full_next;
    logic [c_CNT_W-1:0]   r_wcnt;
    logic [c_CNT_W-1:0]   r_cnt [NUM_BANKS];

    logic                 w_wr_ready;
    logic                 w_wr_fire;
    logic                 w_close;
    logic                 w_bank_valid;
    logic                 w_release;
    logic [c_CNT_W-1:0]   w_rd_count;

    // Read-side signals are sized for two ports; an absent port is tied off.
    logic [1:0]           w_q;
    logic [ADDR_W-1:0]    w_rd_addr [2];
    logic [1:0]           r_rd_valid;
    logic                 r_rd_bank;
    logic [DATA_W-1:0]    w_a_rdata [NUM_BANKS];
    logic [DATA_W-1:0]    w_b_rdata [NUM_BANKS];

    assign w_wr_ready   = !r_full[r_fill_sel] && !rst;
    // Abort wins over a coincident beat.
    assign w_wr_fire    = bus.wr_valid && w_wr_ready && !bus.wr_abort;
    // Auto-close on the last slot keeps a block from ever overflowing a bank.
    assign w_close      = w_wr_fire && (bus.wr_last || (r_wcnt == c_LAST_IDX));
    assign w_bank_valid = r_full[r_drain_sel];
    assign w_release    = bus.rd_release && w_bank_valid;
    assign w_rd_count   = w_bank_valid ? r_cnt[r_drain_sel] : '0;

    // Close and release always target different banks, so both can apply.
    always_comb begin
        w_full_next = r_full;
        if (w_close)   w_full_next[r_fill_sel]  = 1'b1;
        if (w_release) w_full_next[r_drain_sel] = 1'b0;
    end

    // Fill-side write counter, per-bank counts and bank ownership.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_sel  <= 1'b0;
            r_drain_sel <= 1'b0;
            r_full      <= '0;
            r_wcnt      <= '0;
            r_cnt[0]    <= '0;
            r_cnt[1]    <= '0;
        end else begin
            r_full <= w_full_next;
            if (w_release) r_drain_sel <= !r_drain_sel;
            if (bus.wr_abort) begin
                r_wcnt <= '0;
            end else if (w_close) begin
                r_wcnt              <= '0;
                r_cnt[r_fill_sel]   <= r_wcnt + c_ONE;
                r_fill_sel          <= !r_fill_sel;
            end else if (w_wr_fire) begin
                r_wcnt <= r_wcnt + c_ONE;
            end
        end
    end

    // Qualify each read at issue; stale or out-of-range requests never reach
    // the output as valid.
    for (genvar i = 0; i < 2; i++) begin : g_rd_req
        if (i < NUM_RD) begin : g_used
            assign w_rd_addr[i] = bus.rd_addr[i*ADDR_W +: ADDR_W];
            assign w_q[i]       = bus.rd_en[i] && w_bank_valid
                                  && ({1'b0, w_rd_addr[i]} < w_rd_count);
        end else begin : g_unused
            assign w_rd_addr[i] = '0;
            assign w_q[i]       = 1'b0;
        end
    end

    // Per-bank port muxing: fill bank takes writes on port A; drain bank
    // serves read port 0 on A and read port 1 on B. A bank can be both only
    // when it is full, and then writes are blocked.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic              w_is_fill;
        logic              w_is_drain;
        logic              w_a_we;
        logic              w_a_en;
        logic              w_b_en;
        logic [ADDR_W-1:0] w_a_addr;

        assign w_is_fill  = (r_fill_sel  == 1'(b));
        assign w_is_drain = (r_drain_sel == 1'(b));
        assign w_a_we     = w_wr_fire && w_is_fill;
        assign w_a_en     = w_a_we || (w_q[0] && w_is_drain);
        assign w_b_en     = w_q[1] && w_is_drain;
        assign w_a_addr   = w_a_we ? r_wcnt[ADDR_W-1:0] : w_rd_addr[0];

        idx_tdp_ram #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk       (clk),
            .i_a_en    (w_a_en),
            .i_a_we    (w_a_we),
            .i_a_addr  (w_a_addr),
            .i_a_wdata (bus.wr_data),
            .o_a_rdata (w_a_rdata[b]),
            .i_b_en    (w_b_en),
            .i_b_addr  (w_rd_addr[1]),
            .o_b_rdata (w_b_rdata[b])
        );
    end

    // Remember which bank each read targeted, since a same-cycle release
    // moves drain_sel before the data comes back.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= '0;
            r_rd_bank  <= 1'b0;
        end else begin
            r_rd_valid <= w_q;
            r_rd_bank  <= r_drain_sel;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_out
        logic [DATA_W-1:0] w_word;
        if (i == 0) begin : g_port_a
            assign w_word = w_a_rdata[r_rd_bank];
        end else begin : g_port_b
            assign w_word = w_b_rdata[r_rd_bank];
        end
        assign bus.rd_data[i*DATA_W +: DATA_W] = r_rd_valid[i] ? w_word : '0;
        assign bus.rd_data_valid[i]            = r_rd_valid[i];
    end

    assign bus.wr_ready      = w_wr_ready;
    assign bus.rd_bank_valid = w_bank_valid;
    assign bus.rd_count      = w_rd_count;
    assign bus.occupancy     = {1'b0, r_full[0]} + {1'b0, r_full[1]};

endmodule
`default_nettype wire

// File: tb/tb_indice_pingpong_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_indice_pingpong_buffer
//  Description : Directed vector bench for the ping-pong index buffer with
//                K=64 (DEPTH=128, DATA_W=6, ADDR_W=7, two read ports).
//                Each vector drives inputs for one cycle; outputs are checked
//                1 time unit after the rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_indice_pingpong_buffer;

    localparam int unsigned DATA_W = 6;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned NUM_RD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    indice_pingpong_buffer_if #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) bus ();

    indice_pingpong_buffer #(
        .K      (64),
        .DATA_W (DATA_W),
        .DEPTH  (128),
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic              rst;
        logic              wv;
        logic [DATA_W-1:0] wd;
        logic              wl;
        logic              wa;
        logic [1:0]        ren;
        logic [ADDR_W-1:0] a0;
        logic [ADDR_W-1:0] a1;
        logic              rel;
        logic              rdy;
        logic              bv;
        logic [ADDR_W:0]   cnt;
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
        logic [1:0]        dv;
        logic [1:0]        occ;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(int r, int wv, int wd, int wl, int wa, int ren,
                                int a0, int a1, int rel, int rdy, int bv,
                                int cnt, int d0, int d1, int dv, int occ);
        vec_t v;
        v.rst = 1'(r);    v.wv  = 1'(wv);   v.wd  = DATA_W'(wd);
        v.wl  = 1'(wl);   v.wa  = 1'(wa);   v.ren = 2'(ren);
        v.a0  = ADDR_W'(a0); v.a1 = ADDR_W'(a1); v.rel = 1'(rel);
        v.rdy = 1'(rdy);  v.bv  = 1'(bv);   v.cnt = (ADDR_W+1)'(cnt);
        v.d0  = DATA_W'(d0); v.d1 = DATA_W'(d1);
        v.dv  = 2'(dv);   v.occ = 2'(occ);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        if (got !== exp) begin
            n_err++;
            $display("FAIL vec%0d %s: got %0d, expected %0d", n_vec, name, got, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        rst            = v.rst;
        bus.wr_valid   = v.wv;
        bus.wr_data    = v.wd;
        bus.wr_last    = v.wl;
        bus.wr_abort   = v.wa;
        bus.rd_en      = v.ren;
        bus.rd_addr    = {v.a1, v.a0};
        bus.rd_release = v.rel;
        @(posedge clk);
        #1;
        n_vec++;
        chk("wr_ready",      32'(bus.wr_ready),            32'(v.rdy));
        chk("rd_bank_valid", 32'(bus.rd_bank_valid),       32'(v.bv));
        chk("rd_count",      32'(bus.rd_count),            32'(v.cnt));
        chk("rd_data0",      32'(bus.rd_data[DATA_W-1:0]), 32'(v.d0));
        chk("rd_data1",      32'(bus.rd_data[2*DATA_W-1:DATA_W]), 32'(v.d1));
        chk("rd_data_valid", 32'(bus.rd_data_valid),       32'(v.dv));
        chk("occupancy",     32'(bus.occupancy),           32'(v.occ));
    endtask

    initial begin
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.wr_last    = 1'b0;
        bus.wr_abort   = 1'b0;
        bus.rd_en      = '0;
        bus.rd_addr    = '0;
        bus.rd_release = 1'b0;

        //               rst wv wd wl wa ren a0 a1 rel | rdy bv cnt d0 d1 dv occ
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0));
        // Block of 5 beats (1..5) into bank 0
        for (int d = 1; d <= 4; d++)
            tbl.push_back(mk(0, 1, d, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0, 0,   1, 1, 5, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 2, 4, 0,   1, 1, 5, 3, 5, 3, 1));
        // Out of range (7 and count boundary 5), same-address dual read
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 7, 5, 0,   1, 1, 5, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0,   1, 1, 5, 1, 1, 3, 1));
        // Read together with release still returns data
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 1, 3, 1,   1, 0, 0, 2, 4, 3, 0));
        // Read with no valid bank
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0));
        // Bank 1 gets 3 entries, bank 0 gets 4 entries, no release
        tbl.push_back(mk(0, 1, 10, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 11, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 12, 1, 0, 0, 0, 0, 0,  1, 1, 3, 0, 0, 0, 1));
        for (int d = 20; d <= 22; d++)
            tbl.push_back(mk(0, 1, d, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 23, 1, 0, 0, 0, 0, 0,  0, 1, 3, 0, 0, 0, 2));
        // Both full: beat ignored; port1 addr 3 is out of range for count 3
        tbl.push_back(mk(0, 1, 30, 0, 0, 3, 2, 3, 0,  0, 1, 3, 12, 0, 1, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 1, 4, 0, 0, 0, 1));
        // Close bank 1 in the same cycle bank 0 is released
        tbl.push_back(mk(0, 1, 40, 0, 0, 3, 3, 0, 0,  1, 1, 4, 23, 20, 3, 1));
        tbl.push_back(mk(0, 1, 41, 1, 0, 0, 0, 0, 1,  1, 1, 2, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 0, 1, 0,   1, 1, 2, 40, 41, 3, 1));
        // Abort: 3 beats, abort (with a dropped beat), then 2 beats with last
        for (int d = 50; d <= 52; d++)
            tbl.push_back(mk(0, 1, d, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 53, 0, 1, 0, 0, 0, 0,  1, 1, 2, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 60, 0, 0, 0, 0, 0, 0,  1, 1, 2, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 61, 1, 0, 0, 0, 0, 0,  0, 1, 2, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 1, 2, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 0, 1, 0,   1, 1, 2, 60, 61, 3, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // Auto-close: 128 beats with no last fill bank 1 completely.
        for (int i = 0; i < 127; i++)
            apply(mk(0, 1, i % 64, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        apply(mk(0, 1, 127 % 64, 0, 0, 0, 0, 0, 0, 1, 1, 128, 0, 0, 0, 1));
        // Beat 129 lands at address 0 of bank 0 with no bubble.
        apply(mk(0, 1, 7, 1, 0, 0, 0, 0, 0,      0, 1, 128, 0, 0, 0, 2));
        apply(mk(0, 0, 0, 0, 0, 3, 127, 70, 0,   0, 1, 128, 63, 6, 3, 2));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,      1, 1, 1, 0, 0, 0, 1));
        apply(mk(0, 0, 0, 0, 0, 3, 0, 1, 0,      1, 1, 1, 7, 0, 1, 1));

        // Reset mid-stream with a write and reads in flight.
        apply(mk(0, 1, 33, 0, 0, 0, 0, 0, 0,     1, 1, 1, 0, 0, 0, 1));
        apply(mk(0, 1, 34, 0, 0, 0, 0, 0, 0,     1, 1, 1, 0, 0, 0, 1));
        apply(mk(1, 1, 35, 0, 0, 3, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      1, 0, 0, 0, 0, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 3, 0, 0, 0,      1, 0, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
